// File: rtl/ipg_tx_multi.sv
// ipg_tx_multi
//   Inserts queued 48-bit messages from NUM_CH channel FIFOs into idle
//   64b/66b blocks of a transmit stream. Frames (start .. terminate) and
//   GUARD_BLOCKS idles after each terminate always pass unmodified. Every
//   block leaves exactly one cycle after it arrives.
//
// Ports
//   clk, rst_n          single clock, async active-low reset
//   encoded_tx_data/hdr block from the encoder, one per cycle
//   msg_data/msg_valid  per-channel message write (channel c at [48c+:48])
//   msg_ready           per-channel FIFO not full
//   proced_tx_data/hdr  output block (registered)
//   tx_pause            some channel FIFO is full
//   msg_drop            one-cycle pulse for a write that found its FIFO full
//   ins_count           per-channel saturating insertion counters, present
//                       only when IPG_TX_MULTI_STATS_EN is defined
//
// Optional feature macro: IPG_TX_MULTI_STATS_EN

// Per-channel message FIFO.
//   wr_valid/wr_data  write request
//   rd_en             pop the head entry (only asserted when not_empty)
//   rd_data           head entry
//   ready             not full
//   not_empty         at least one entry queued
//   drop              registered pulse for a rejected write
module ipg_tx_ch_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         ready,
  output logic         not_empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, wr_acc, rd_acc;

  assign full      = (cnt == FULL_CNT);
  assign ready     = ~full;
  assign not_empty = (cnt != '0);
  assign rd_data   = mem[rd_ptr];
  assign rd_acc    = rd_en && not_empty;
  // A pop in the same cycle frees a slot, so a write against a full FIFO
  // still lands; ready stays low for that cycle and occupancy holds.
  assign wr_acc    = wr_valid && (!full || rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= wr_valid && !wr_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end
endmodule

module ipg_tx_multi #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          HDR_WIDTH    = 2,
  parameter int          NUM_CH       = 4,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          GUARD_BLOCKS = 1,
  parameter logic [7:0]  MSG_BTYPE    = 8'h4B
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  input  logic [NUM_CH*48-1:0]  msg_data,
  input  logic [NUM_CH-1:0]     msg_valid,
  output logic [NUM_CH-1:0]     msg_ready,
  output logic [DATA_WIDTH-1:0] proced_tx_data,
  output logic [HDR_WIDTH-1:0]  proced_tx_hdr,
  output logic                  tx_pause,
  output logic [NUM_CH-1:0]     msg_drop
`ifdef IPG_TX_MULTI_STATS_EN
  ,output logic [NUM_CH*32-1:0] ins_count
`endif
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [HDR_WIDTH-1:0]  HDR_CTRL = HDR_WIDTH'(2'b10);
  localparam logic [DATA_WIDTH-1:0] IDLE_BLK = DATA_WIDTH'(8'h1E);

  typedef enum logic [1:0] {ST_OPEN, ST_FRAME, ST_GUARD} state_t;

  typedef struct packed {
    logic [HDR_WIDTH-1:0]  hdr;
    logic [DATA_WIDTH-1:0] data;
  } blk_t;

  state_t                    state;
  logic [3:0]                guard_cnt;
  logic [4:0]                guard_nxt;
  logic [CW-1:0]             rr_ptr;
  blk_t                      in_blk, out_blk;

  logic [NUM_CH-1:0][47:0]   msg_pl;
  logic [NUM_CH-1:0][47:0]   head;
  logic [NUM_CH-1:0]         not_empty, pop;

  logic                      is_ctrl, is_idle, is_start, is_term;
  logic                      gnt_vld, insert;
  logic [CW-1:0]             gnt_ch;

  assign msg_pl = msg_data;
  assign in_blk = '{hdr: encoded_tx_hdr, data: encoded_tx_data};

  // ---------------- block classification ----------------
  assign is_ctrl  = (encoded_tx_hdr == HDR_CTRL);
  assign is_idle  = is_ctrl && (encoded_tx_data == IDLE_BLK);
  assign is_start = is_ctrl && (encoded_tx_data[7:0] inside {8'h78, 8'h33});
  assign is_term  = is_ctrl && (encoded_tx_data[7:0] inside
                    {8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF});

  // ---------------- per-channel FIFOs ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ipg_tx_ch_fifo #(.DEPTH(FIFO_DEPTH), .W(48)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (msg_valid[c]),
      .wr_data   (msg_pl[c]),
      .rd_en     (pop[c]),
      .rd_data   (head[c]),
      .ready     (msg_ready[c]),
      .not_empty (not_empty[c]),
      .drop      (msg_drop[c])
    );
    assign pop[c] = insert && (gnt_ch == CW'(c));
  end

  assign tx_pause = ~&msg_ready;

  // ---------------- round-robin grant ----------------
  // rr_ptr holds the first channel to look at: the one after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && not_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(idx);
      end
    end
  end

  assign insert    = (state == ST_OPEN) && is_idle && gnt_vld;
  assign guard_nxt = {1'b0, guard_cnt} + 5'd1;

  // Message block: payload, then channel byte (upper 5 bits zero), then type.
  always_comb begin
    out_blk = in_blk;
    if (insert) begin
      out_blk.hdr  = HDR_CTRL;
      out_blk.data = DATA_WIDTH'({head[gnt_ch], 8'(gnt_ch), MSG_BTYPE});
    end
  end

  // ---------------- FSM + registered output ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_OPEN;
      guard_cnt      <= '0;
      rr_ptr         <= '0;
      proced_tx_data <= IDLE_BLK;
      proced_tx_hdr  <= HDR_CTRL;
    end else begin
      proced_tx_data <= out_blk.data;
      proced_tx_hdr  <= out_blk.hdr;

      if (insert)
        rr_ptr <= (gnt_ch == CW'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;

      // A start block opens a frame from any state.
      if (is_start) begin
        state <= ST_FRAME;
      end else begin
        case (state)
          ST_FRAME: if (is_term) begin
            guard_cnt <= '0;
            state     <= (GUARD_BLOCKS == 0) ? ST_OPEN : ST_GUARD;
          end
          ST_GUARD: if (is_idle) begin
            guard_cnt <= guard_nxt[3:0];
            if (guard_nxt == 5'(GUARD_BLOCKS)) state <= ST_OPEN;
          end
          default: state <= state;
        endcase
      end
    end
  end

  // ---------------- optional insertion statistics ----------------
`ifdef IPG_TX_MULTI_STATS_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt_q <= '0;
      else if (pop[c] && ~&cnt_q)    cnt_q <= cnt_q + 32'd1;
    end
    assign ins_count[32*c +: 32] = cnt_q;
  end
`else
  // Statistics disabled: no counters and no ins_count port.
`endif
endmodule

// File: tb/tb_ipg_tx_multi.sv
module tb_ipg_tx_multi;
  localparam int NUM_CH = 4;
  localparam logic [63:0] IDLE = 64'h1E;
  localparam logic [63:0] DBLK = 64'h5555_AAAA_1234_5678;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [63:0]           enc_data = IDLE;
  logic [1:0]            enc_hdr = 2'b10;
  logic [NUM_CH*48-1:0]  msg_data = '0;
  logic [NUM_CH-1:0]     msg_valid = '0;
  logic [NUM_CH-1:0]     msg_ready, msg_drop;
  logic [63:0]           out_data;
  logic [1:0]            out_hdr;
  logic                  tx_pause;
`ifdef IPG_TX_MULTI_STATS_EN
  logic [NUM_CH*32-1:0]  ins_count;
`endif

  int checks = 0;
  int errors = 0;

  ipg_tx_multi #(.NUM_CH(NUM_CH), .FIFO_DEPTH(4), .GUARD_BLOCKS(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .encoded_tx_data (enc_data),
    .encoded_tx_hdr  (enc_hdr),
    .msg_data        (msg_data),
    .msg_valid       (msg_valid),
    .msg_ready       (msg_ready),
    .proced_tx_data  (out_data),
    .proced_tx_hdr   (out_hdr),
    .tx_pause        (tx_pause),
    .msg_drop        (msg_drop)
`ifdef IPG_TX_MULTI_STATS_EN
    ,.ins_count      (ins_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Present one block, let it be clocked in, sample #1 after the edge.
  task automatic cyc(input logic [1:0] h, input logic [63:0] d);
    enc_hdr  = h;
    enc_data = d;
    @(posedge clk);
    #1;
    msg_valid = '0;
  endtask

  task automatic put(input int ch, input logic [47:0] pl);
    msg_valid[ch]         = 1'b1;
    msg_data[ch*48 +: 48] = pl;
  endtask

  function automatic logic [63:0] mblk(input logic [47:0] pl, input int ch);
    return {pl, 8'(ch), 8'h4B};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset values ----
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  out_data, IDLE);
    chk("rst_hdr",   64'(out_hdr), 64'h2);
    chk("rst_ready", 64'(msg_ready), 64'hF);
    chk("rst_pause", 64'(tx_pause), 64'h0);
    chk("rst_drop",  64'(msg_drop), 64'h0);
    rst_n = 1'b1;

    // ---- single ch0 message into idle stream ----
    put(0, 48'h0102_0304_0506);
    cyc(2'b10, IDLE);
    chk("wr_cycle_idle", out_data, IDLE);
    cyc(2'b10, IDLE);
    chk("ins0_data", out_data, 64'h0102_0304_0506_004B);
    chk("ins0_hdr",  64'(out_hdr), 64'h2);
    cyc(2'b10, IDLE);
    chk("post_idle", out_data, IDLE);

    // ---- round robin over four channels from fresh reset ----
    do_reset();
    for (int c = 0; c < 4; c++) put(c, 48'hA0A0_0000_0000 | 48'(c));
    cyc(2'b01, DBLK);
    chk("rr_pass_data", out_data, DBLK);
    chk("rr_pass_hdr",  64'(out_hdr), 64'h1);
    for (int c = 0; c < 4; c++) begin
      cyc(2'b10, IDLE);
      chk($sformatf("rr_ch%0d", c), out_data, mblk(48'hA0A0_0000_0000 | 48'(c), c));
    end
    cyc(2'b10, IDLE);
    chk("rr_empty_idle", out_data, IDLE);

    // ---- frame, terminate, two guard idles, then insertion ----
    put(1, 48'hC1C1_C1C1_C1C1);
    cyc(2'b10, 64'h0011_2233_4455_6678);
    chk("frm_start", out_data, 64'h0011_2233_4455_6678);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, DBLK + 64'(i));
      chk("frm_data", out_data, DBLK + 64'(i));
    end
    cyc(2'b10, IDLE);             // idle inside frame: not an insertion slot
    chk("frm_idle", out_data, IDLE);
    cyc(2'b10, 64'h0000_0000_0000_00FF);
    chk("frm_term", out_data, 64'h0000_0000_0000_00FF);
    cyc(2'b10, IDLE);
    chk("guard1", out_data, IDLE);
    cyc(2'b10, IDLE);
    chk("guard2", out_data, IDLE);
    cyc(2'b10, IDLE);
    chk("guard_ins_ch1", out_data, mblk(48'hC1C1_C1C1_C1C1, 1));

    // ---- fill ch2 (depth 4), drop, simultaneous write+pop, drain ----
    for (int k = 0; k < 4; k++) begin
      put(2, 48'h2200_0000_0000 | 48'(k));
      cyc(2'b01, DBLK);
      chk($sformatf("fill_ready%0d", k), 64'(msg_ready[2]), (k < 3) ? 64'h1 : 64'h0);
      chk($sformatf("fill_pause%0d", k), 64'(tx_pause),     (k < 3) ? 64'h0 : 64'h1);
    end
    put(2, 48'h2200_0000_0004);
    cyc(2'b01, DBLK);
    chk("drop_pulse", 64'(msg_drop), 64'h4);
    put(2, 48'h2200_0000_0005);   // accepted: same-cycle pop frees a slot
    cyc(2'b10, IDLE);
    chk("full_rw_out",   out_data, mblk(48'h2200_0000_0000, 2));
    chk("full_rw_drop",  64'(msg_drop), 64'h0);
    chk("full_rw_ready", 64'(msg_ready[2]), 64'h0);
    chk("full_rw_pause", 64'(tx_pause), 64'h1);
    cyc(2'b10, IDLE);
    chk("drain1", out_data, mblk(48'h2200_0000_0001, 2));
    cyc(2'b10, IDLE);
    chk("drain2", out_data, mblk(48'h2200_0000_0002, 2));
    cyc(2'b10, IDLE);
    chk("drain3", out_data, mblk(48'h2200_0000_0003, 2));
    cyc(2'b10, IDLE);
    chk("drain5", out_data, mblk(48'h2200_0000_0005, 2));
    chk("drain_pause", 64'(tx_pause), 64'h0);
    chk("drain_ready", 64'(msg_ready), 64'hF);
    cyc(2'b10, IDLE);
    chk("drain_empty", out_data, IDLE);

    // ---- async reset mid-frame with queued messages ----
    put(0, 48'h1);
    put(1, 48'h2);
    put(3, 48'h3);
    cyc(2'b10, 64'h0000_0000_0000_0033);
    chk("mid_start", out_data, 64'h33);
    cyc(2'b01, DBLK);
    chk("mid_data", out_data, DBLK);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data",  out_data, IDLE);
    chk("async_hdr",   64'(out_hdr), 64'h2);
    chk("async_ready", 64'(msg_ready), 64'hF);
    chk("async_pause", 64'(tx_pause), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2'b01, DBLK);
    chk("rel_data", out_data, DBLK);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b10, IDLE);
      chk($sformatf("rel_idle%0d", i), out_data, IDLE);
    end

`ifdef IPG_TX_MULTI_STATS_EN
    // ---- insertion statistics ----
    for (int i = 0; i < 3; i++) begin
      put(0, 48'h00AB_0000_0000 | 48'(i));
      cyc(2'b01, DBLK);
    end
    for (int i = 0; i < 3; i++) cyc(2'b10, IDLE);
    chk("stat_ch0",  64'(ins_count[31:0]), 64'd3);
    chk("stat_ch1",  64'(ins_count[63:32]), 64'd0);
    chk("stat_ch23", ins_count[127:64], 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ipg_tx_multi.md
IPG_TX_MULTI -- requirements
Module: ipg_tx_multi

Interface
REQ-001 Parameter DATA_WIDTH, 64, encoded block payload width; only 64 is legal.
REQ-002 Parameter HDR_WIDTH, 2, sync header width; only 2 is legal.
REQ-003 Parameter NUM_CH, 4, number of message channels, 1..8.
REQ-004 Parameter FIFO_DEPTH, 16, entries per channel FIFO, power of two, 2..256.
REQ-005 Parameter GUARD_BLOCKS, 1, idle blocks after a terminate block that pass unmodified, 0..15.
REQ-006 Parameter MSG_BTYPE, 8'h4B, block type byte marking a message block.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 encoded_tx_data  in  64  64b/66b block payload from the encoder, valid every cycle.
REQ-010 encoded_tx_hdr  in  2  sync header for encoded_tx_data.
REQ-011 msg_data  in  NUM_CH*48  per-channel 48-bit message payload, channel c at [48c+47:48c].
REQ-012 msg_valid  in  NUM_CH  per-channel write strobe.
REQ-013 msg_ready  out  NUM_CH  per-channel FIFO not full.
REQ-014 proced_tx_data  out  64  output block payload, idle replaced by message where granted.
REQ-015 proced_tx_hdr  out  2  output sync header.
REQ-016 tx_pause  out  1  high when any channel FIFO is full.
REQ-017 msg_drop  out  NUM_CH  one-cycle pulse when msg_valid arrives while msg_ready is low.

Function
REQ-018 Channel write accepted when msg_valid[c] and msg_ready[c] in the same cycle; rejected writes discarded, msg_drop[c] pulsed next cycle.
REQ-019 Simultaneous accepted write and read on a full FIFO: both occur; msg_ready stays low that cycle, occupancy unchanged.
REQ-020 Idle block: hdr 2'b10, data[7:0]=8'h1E, data[63:8]=0.
REQ-021 Start block: hdr 2'b10, type 8'h78 or 8'h33; terminate block: hdr 2'b10, type in {87,99,AA,B4,CC,D2,E1,FF}.
REQ-022 FSM states FRAME, GUARD, OPEN; reset state OPEN.
REQ-023 Any state: start block -> FRAME; FRAME: terminate -> GUARD with guard_cnt=0 (GUARD_BLOCKS=0 -> OPEN directly).
REQ-024 GUARD: each idle block increments guard_cnt; reaching GUARD_BLOCKS -> OPEN; idle blocks in GUARD pass unmodified.
REQ-025 OPEN: idle input block with any FIFO non-empty is replaced by {payload[47:0], 5'b0, ch[2:0], MSG_BTYPE}, hdr 2'b10, and that FIFO popped.
REQ-026 Channel selection round-robin starting after last granted channel; pointer advances only on a grant.
REQ-027 Non-idle blocks and all blocks in FRAME/GUARD pass unchanged.
REQ-028 Latency input to output exactly 1 cycle, registered, in every state.
REQ-029 Occupancy counters width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 rst_n low asynchronously: all FIFOs empty, FSM OPEN, RR pointer 0, guard_cnt 0.
REQ-031 During reset: proced_tx_data=64'h1E, proced_tx_hdr=2'b10, msg_ready all 1, tx_pause 0, msg_drop 0.
REQ-032 Reset deassertion mid-frame: first block after release classified normally; no message inserted until an idle arrives in OPEN.

Configuration
REQ-033 Macro IPG_TX_MULTI_STATS_EN defined: add output ins_count (NUM_CH*32), per-channel saturating count of inserted message blocks, cleared by reset, saturating at 32'hFFFFFFFF.
REQ-034 Macro undefined: no ins_count port, no counter logic; all other behaviour identical.

Verification
REQ-035 Write ch0 payload 48'h0102_0304_0506, then continuous idles -> 1 cycle later output 64'h0102_0304_0506_004B, hdr 2'b10; following idles unchanged.
REQ-036 One message in each of ch0..ch3, continuous idles -> insertions in order ch0,ch1,ch2,ch3, channel byte bits[10:8]=0,1,2,3.
REQ-037 Frame start, 3 data blocks, terminate 8'hFF, idles with GUARD_BLOCKS=2 and ch1 pending -> first two idles unchanged, third idle carries ch1 message.
REQ-038 FIFO_DEPTH=4, 5 writes to ch2 with no idles -> msg_ready[2]=0 after 4th, tx_pause=1, 5th produces msg_drop[2] pulse; 4 idles drain it, tx_pause returns 0.
REQ-039 rst_n low mid-frame with 3 queued messages -> outputs at reset values asynchronously; after release, idles pass unmodified (FIFOs empty).
REQ-040 IPG_TX_MULTI_STATS_EN defined, 3 ch0 insertions -> ins_count[31:0]=3, other channels 0.
